// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply/divide unit with HI/LO result registers.
// One shift-add (multu) or restoring shift-subtract (divu) step per cycle.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             dbz
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] opnd, acc, sh, acc_n, sh_n;
  logic [WIDTH:0]   mul_sum, div_trial, div_diff;
  logic             last;

  // acc/sh hold {product upper, multiplier} in MUL and {remainder, dividend} in DIV,
  // so both operations end with hi=acc and lo=sh.
  always_comb begin
    mul_sum   = {1'b0, acc} + (sh[0] ? {1'b0, opnd} : '0);
    div_trial = {acc, sh[WIDTH-1]};
    div_diff  = div_trial - {1'b0, opnd};
    acc_n     = acc;
    sh_n      = sh;
    if (state == MUL) begin
      acc_n = mul_sum[WIDTH:1];
      sh_n  = {mul_sum[0], sh[WIDTH-1:1]};
    end else if (state == DIV) begin
      if (!div_diff[WIDTH]) begin
        acc_n = div_diff[WIDTH-1:0];
        sh_n  = {sh[WIDTH-2:0], 1'b1};
      end else begin
        acc_n = div_trial[WIDTH-1:0];
        sh_n  = {sh[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign last = (cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (op == 2'b00)      state_n = MUL;
          else if (op == 2'b01) state_n = (b == '0) ? FIN : DIV;
        end
      end
      MUL, DIV: if (last) state_n = FIN;
      FIN:      state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // hi/lo change only on moves, divide-by-zero, or the final iteration edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      opnd <= '0;
      acc  <= '0;
      sh   <= '0;
      hi   <= '0;
      lo   <= '0;
      dbz  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            case (op)
              2'b00: begin
                opnd <= a;
                acc  <= '0;
                sh   <= b;
                cnt  <= '0;
                dbz  <= 1'b0;
              end
              2'b01: begin
                if (b == '0) begin
                  hi  <= a;
                  lo  <= '1;
                  dbz <= 1'b1;
                end else begin
                  opnd <= b;
                  acc  <= '0;
                  sh   <= a;
                  cnt  <= '0;
                  dbz  <= 1'b0;
                end
              end
              2'b10:   hi <= a;
              default: lo <= a;
            endcase
          end
        end
        MUL, DIV: begin
          acc <= acc_n;
          sh  <= sh_n;
          cnt <= cnt + CNT_W'(1);
          if (last) begin
            hi <= acc_n;
            lo <= sh_n;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == MUL) || (state == DIV);
  assign done = (state == FIN);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed, table-driven bench for muldiv_unit at WIDTH=32.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done, dbz;
  logic [31:0] hi, lo;

  int total_checks = 0;
  int passed_checks = 0;

  muldiv_unit #(.WIDTH(32), .CNT_W(7)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .dbz(dbz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_checks++;
    if (act === exp) passed_checks++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Called at a falling edge; start is sampled by the next rising edge.
  // inject>0 pulses a divu request while the operation is running.
  task automatic applyStimulus(input logic [1:0] s_op, input logic [31:0] s_a, input logic [31:0] s_b,
                               input int inject, output int lat, output int busy_cnt,
                               output bit stable, output logic done_after);
    logic [31:0] hi0, lo0;
    hi0 = hi;
    lo0 = lo;
    start = 1'b1;
    op = s_op;
    a = s_a;
    b = s_b;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    busy_cnt = 0;
    stable = 1'b1;
    while (!done && lat < 100) begin
      if (busy) busy_cnt++;
      if (hi !== hi0 || lo !== lo0) stable = 1'b0;
      if (inject != 0 && lat == inject) begin
        start = 1'b1;
        op = 2'b01;
        a = 32'd1000;
        b = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    @(negedge clk);
    done_after = done;
  endtask

  int lat, busy_cnt;
  bit stable;
  logic done_after;
  bit saw_done;

  initial begin
    vecs[0]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33};
    vecs[1]  = '{2'b01, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 33};
    vecs[2]  = '{2'b01, 32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, 1'b1, 1};
    vecs[3]  = '{2'b00, 32'd3,        32'd5,        32'd0,        32'd15,       1'b0, 33};
    vecs[4]  = '{2'b00, 32'h80000000, 32'd4,        32'd2,        32'd0,        1'b0, 33};
    vecs[5]  = '{2'b01, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 1'b0, 33};
    vecs[6]  = '{2'b01, 32'd5,        32'd9,        32'd5,        32'd0,        1'b0, 33};
    vecs[7]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1,        1'b0, 33};
    vecs[8]  = '{2'b00, 32'h00010000, 32'h00010000, 32'd1,        32'd0,        1'b0, 33};
    vecs[9]  = '{2'b01, 32'd1000000,  32'd1000,     32'd0,        32'd1000,     1'b0, 33};
    vecs[10] = '{2'b01, 32'hDEADBEEF, 32'h10,       32'hF,        32'h0DEADBEE, 1'b0, 33};
    vecs[11] = '{2'b00, 32'd0,        32'h0000FFFF, 32'd0,        32'd0,        1'b0, 33};

    rst = 1'b1;
    start = 1'b0;
    op = 2'b00;
    a = '0;
    b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset hi", hi, 0);
    checkOutput("reset lo", lo, 0);
    checkOutput("reset dbz", dbz, 0);

    // Back-to-back: each call drives start in the idle cycle right after FIN.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, 0, lat, busy_cnt, stable, done_after);
      checkOutput($sformatf("vec%0d latency", i), lat, vecs[i].lat);
      checkOutput($sformatf("vec%0d busy cycles", i), busy_cnt, vecs[i].lat - 1);
      checkOutput($sformatf("vec%0d hi", i), hi, vecs[i].hi);
      checkOutput($sformatf("vec%0d lo", i), lo, vecs[i].lo);
      checkOutput($sformatf("vec%0d dbz", i), dbz, vecs[i].dbz);
      checkOutput($sformatf("vec%0d hilo stable", i), stable, 1);
      checkOutput($sformatf("vec%0d done width", i), done_after, 0);
    end

    // Divide by zero followed by a multiply clears dbz.
    applyStimulus(2'b01, 32'h1234, 32'd0, 0, lat, busy_cnt, stable, done_after);
    checkOutput("dbz set", dbz, 1);
    applyStimulus(2'b00, 32'd3, 32'd5, 0, lat, busy_cnt, stable, done_after);
    checkOutput("dbz cleared", dbz, 0);
    checkOutput("3x5 lo", lo, 15);
    checkOutput("3x5 hi", hi, 0);

    // A divu pulsed mid-multiply is ignored.
    applyStimulus(2'b00, 32'd2, 32'd3, 9, lat, busy_cnt, stable, done_after);
    checkOutput("ignore lat", lat, 33);
    checkOutput("ignore lo", lo, 6);
    checkOutput("ignore hi", hi, 0);
    checkOutput("ignore stable", stable, 1);
    checkOutput("ignore idle after", busy, 0);
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    checkOutput("ignore no second op", saw_done, 0);

    // Reset in the middle of a multiply.
    applyStimulus(2'b01, 32'h1234, 32'd0, 0, lat, busy_cnt, stable, done_after);
    start = 1'b1;
    op = 2'b00;
    a = 32'd7;
    b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (13) @(negedge clk);
    checkOutput("pre-reset busy", busy, 1);
    checkOutput("pre-reset hi held", hi, 32'h1234);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort busy", busy, 0);
    checkOutput("abort hi", hi, 0);
    checkOutput("abort lo", lo, 0);
    checkOutput("abort done", done, 0);
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    checkOutput("abort no done", saw_done, 0);

    // Reset wins over a simultaneous start.
    rst = 1'b1;
    start = 1'b1;
    op = 2'b00;
    a = 32'd5;
    b = 32'd5;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    checkOutput("rst priority busy", busy, 0);
    @(negedge clk);
    checkOutput("rst priority still idle", busy, 0);

    // Moves into hi and lo.
    start = 1'b1;
    op = 2'b10;
    a = 32'hA5A5A5A5;
    @(negedge clk);
    start = 1'b0;
    checkOutput("mthi hi", hi, 32'hA5A5A5A5);
    checkOutput("mthi done", done, 0);
    checkOutput("mthi busy", busy, 0);
    start = 1'b1;
    op = 2'b11;
    a = 32'h5A5A5A5A;
    @(negedge clk);
    start = 1'b0;
    checkOutput("mtlo lo", lo, 32'h5A5A5A5A);
    checkOutput("mtlo hi kept", hi, 32'hA5A5A5A5);
    checkOutput("mtlo done", done, 0);
    @(negedge clk);
    checkOutput("move no done later", done, 0);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
